// File: rtl/dm_abs_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_abs_cmd_pkg
// Purpose  : Shared definitions for the Debug Module abstract-command
//            executor: command field positions, cmderr codes, regno ranges.
// Revision : 1.0 - initial release
// ============================================================================
package dm_abs_cmd_pkg;

  // Bit positions of the Access Register command fields
  localparam int CMD_CMDTYPE_MSB = 31;
  localparam int CMD_CMDTYPE_LSB = 24;
  localparam int CMD_AARSIZE_MSB = 22;
  localparam int CMD_AARSIZE_LSB = 20;
  localparam int CMD_POSTEXEC    = 18;
  localparam int CMD_TRANSFER    = 17;
  localparam int CMD_WRITE       = 16;
  localparam int CMD_REGNO_MSB   = 15;
  localparam int CMD_REGNO_LSB   = 0;

  // abstractcs.cmderr encoding
  typedef logic [2:0] cmderr_t;
  localparam cmderr_t CMDERR_NONE       = 3'd0;
  localparam cmderr_t CMDERR_BUSY       = 3'd1;
  localparam cmderr_t CMDERR_NOTSUP     = 3'd2;
  localparam cmderr_t CMDERR_EXCEPT     = 3'd3;
  localparam cmderr_t CMDERR_HALTRESUME = 3'd4;

  // Supported regno windows: CSRs then GPR x0..x31
  localparam logic [15:0] CSR_MAX  = 16'h0FFF;
  localparam logic [15:0] GPR_BASE = 16'h1000;
  localparam logic [15:0] GPR_MAX  = 16'h101F;

  // Only 32-bit register accesses are implemented
  localparam logic [2:0] AARSIZE_32 = 3'd2;

  // The fields of a captured command that the executor acts on
  typedef struct packed {
    logic [7:0]  cmdtype;
    logic [2:0]  aarsize;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } abs_cmd_t;

  // True when regno addresses a CSR or a GPR the core can reach
  function automatic logic regno_supported(input logic [15:0] regno);
    return (regno <= CSR_MAX) || ((regno >= GPR_BASE) && (regno <= GPR_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_abs_cmd.sv
`default_nettype none
// ============================================================================
// Module   : dm_abs_cmd
// Purpose  : Debug Module abstract-command executor. Validates Access
//            Register commands, runs them over a req/ack port into the halted
//            core, returns a cmd_finished pulse with read data, and keeps the
//            sticky cmderr code and busy flag for abstractcs.
// Revision : 1.0 - initial release
// ============================================================================
module dm_abs_cmd
  import dm_abs_cmd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [DATA_W-1:0] command,
  input  logic              cmd_update,
  input  logic [DATA_W-1:0] data0,
  output logic              cmd_finished,
  output logic [DATA_W-1:0] cmd_read_data,
  output logic              cmd_busy,
  output logic [2:0]        cmd_err,
  input  logic              cmderr_clr,
  input  logic              core_halted,
  output logic              dbg_reg_req,
  output logic              dbg_reg_we,
  output logic [15:0]       dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_wdata,
  input  logic              dbg_reg_ack,
  input  logic [DATA_W-1:0] dbg_reg_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter value of the last REQ cycle before giving up on the core
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  abs_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmderr_t           err_q, err_d;

  cmderr_t           fsm_err;   // error raised by the FSM this cycle
  logic              busy_err;  // new command arrived while one is running
  logic              req_act;

  // Reserved command bits carry no meaning for Access Register
  logic unused_cmd;
  if (DATA_W > 32) begin : g_cmd_wide
    assign unused_cmd = ^{command[23], command[19], command[DATA_W-1:32]};
  end else begin : g_cmd_narrow
    assign unused_cmd = ^{command[23], command[19]};
  end

  assign busy_err = cmd_update && (state_q != S_IDLE);

  // Command FSM: capture, validate, run core access, report completion
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fsm_err = CMDERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (cmd_update) begin
          cmd_d.cmdtype  = command[CMD_CMDTYPE_MSB:CMD_CMDTYPE_LSB];
          cmd_d.aarsize  = command[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB];
          cmd_d.postexec = command[CMD_POSTEXEC];
          cmd_d.transfer = command[CMD_TRANSFER];
          cmd_d.write    = command[CMD_WRITE];
          cmd_d.regno    = command[CMD_REGNO_MSB:CMD_REGNO_LSB];
          data_d         = data0;
          // Cleared here so errors and writes report zero read data
          rdata_d        = '0;
          state_d        = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_q.cmdtype != 8'd0) begin
          fsm_err = CMDERR_NOTSUP;
        end else if (cmd_q.aarsize != AARSIZE_32) begin
          fsm_err = CMDERR_NOTSUP;
        end else if (cmd_q.postexec) begin
          fsm_err = CMDERR_NOTSUP;
        end else if (cmd_q.transfer && !regno_supported(cmd_q.regno)) begin
          fsm_err = CMDERR_NOTSUP;
        end else if (!core_halted) begin
          fsm_err = CMDERR_HALTRESUME;
        end
        if ((fsm_err != CMDERR_NONE) || !cmd_q.transfer) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still counts as success
        if (dbg_reg_ack) begin
          if (!cmd_q.write) begin
            rdata_d = dbg_reg_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fsm_err = CMDERR_EXCEPT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky cmderr: first error wins; clear beats FSM errors but not busy errors
  always_comb begin
    err_d = err_q;
    if (cmderr_clr) begin
      err_d = CMDERR_NONE;
    end
    if (busy_err) begin
      // A simultaneous FSM error is dropped; the busy report takes the slot
      if (err_d == CMDERR_NONE) begin
        err_d = CMDERR_BUSY;
      end
    end else if (!cmderr_clr && (err_q == CMDERR_NONE) && (fsm_err != CMDERR_NONE)) begin
      err_d = fsm_err;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= CMDERR_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset drops them immediately
  assign req_act       = (state_q == S_REQ);
  assign cmd_busy      = (state_q != S_IDLE);
  assign cmd_finished  = (state_q == S_DONE);
  assign cmd_read_data = cmd_finished ? rdata_q : '0;
  assign cmd_err       = err_q;
  assign dbg_reg_req   = req_act;
  assign dbg_reg_we    = req_act & cmd_q.write;
  assign dbg_reg_addr  = req_act ? cmd_q.regno : 16'h0000;
  assign dbg_reg_wdata = req_act ? data_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dm_abs_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_abs_cmd
// Purpose  : Self-checking bench for dm_abs_cmd: directed scenarios followed
//            by randomized commands checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_abs_cmd;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic              sys_clk = 1'b0;
  logic              sys_rstn;
  logic [DATA_W-1:0] command;
  logic              cmd_update;
  logic [DATA_W-1:0] data0;
  logic              cmd_finished;
  logic [DATA_W-1:0] cmd_read_data;
  logic              cmd_busy;
  logic [2:0]        cmd_err;
  logic              cmderr_clr;
  logic              core_halted;
  logic              dbg_reg_req;
  logic              dbg_reg_we;
  logic [15:0]       dbg_reg_addr;
  logic [DATA_W-1:0] dbg_reg_wdata;
  logic              dbg_reg_ack;
  logic [DATA_W-1:0] dbg_reg_rdata;

  int checks = 0;
  int errors = 0;
  int err_m  = 0;   // model of the sticky cmderr value

  always #5 sys_clk = ~sys_clk;

  dm_abs_cmd #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rstn     (sys_rstn),
    .command      (command),
    .cmd_update   (cmd_update),
    .data0        (data0),
    .cmd_finished (cmd_finished),
    .cmd_read_data(cmd_read_data),
    .cmd_busy     (cmd_busy),
    .cmd_err      (cmd_err),
    .cmderr_clr   (cmderr_clr),
    .core_halted  (core_halted),
    .dbg_reg_req  (dbg_reg_req),
    .dbg_reg_we   (dbg_reg_we),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_wdata(dbg_reg_wdata),
    .dbg_reg_ack  (dbg_reg_ack),
    .dbg_reg_rdata(dbg_reg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Error code the command earns at validation time (0 = accepted)
  function automatic int exp_code(input logic [31:0] cmd, input logic halted);
    logic [15:0] r;
    r = cmd[15:0];
    if (cmd[31:24] != 8'h00) return 2;
    if (cmd[22:20] != 3'd2)  return 2;
    if (cmd[18])             return 2;
    if (cmd[17] && (r >= 16'h1020)) return 2;   // CSR and GPR windows are contiguous
    if (!halted)             return 4;
    return 0;
  endfunction

  function automatic logic [31:0] rand_cmd();
    logic [7:0]  ct;
    logic [2:0]  sz;
    logic        pe, tr, wr;
    logic [15:0] rg;
    int          sel;
    ct  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    sz  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
    pe  = ($urandom_range(0, 9) == 0);
    tr  = ($urandom_range(0, 3) != 0);
    wr  = 1'($urandom);
    sel = $urandom_range(0, 3);
    if (sel == 0)      rg = 16'($urandom_range(0, 16'h0FFF));
    else if (sel == 1) rg = 16'h1000 + 16'($urandom_range(0, 31));
    else if (sel == 2) rg = 16'($urandom_range(16'h1020, 16'hFFFF));
    else               rg = 16'($urandom);
    return {ct, 1'($urandom), sz, 1'($urandom), pe, tr, wr, rg};
  endfunction

  task automatic clr_err();
    @(negedge sys_clk);
    cmderr_clr = 1'b1;
    @(negedge sys_clk);
    cmderr_clr = 1'b0;
    err_m = 0;
    chk("err_clr", 32'(cmd_err), 32'(err_m));
  endtask

  // Issue one command; the core acks on its dly-th request cycle (dly >= TIMEOUT: never)
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0, input logic halted,
                         input int dly, input logic [31:0] rd);
    int          code, fin_exp, nreq_exp, i, fin_obs, nreq;
    logic [15:0] a_obs;
    logic        we_obs;
    logic [31:0] wd_obs, rd_obs, rd_exp;
    bit          leak, busy_bad;
    code   = exp_code(cmd, halted);
    fin_exp = 2;
    rd_exp = 32'h0;
    if (code == 0 && cmd[17]) begin
      if (dly < TIMEOUT) begin
        fin_exp = 3 + dly;
        if (!cmd[16]) rd_exp = rd;
      end else begin
        fin_exp = 2 + TIMEOUT;
        code    = 3;
      end
    end
    nreq_exp = fin_exp - 2;
    a_obs = 16'h0; we_obs = 1'b0; wd_obs = 32'h0; rd_obs = 32'h0;
    leak = 0; busy_bad = 0; fin_obs = 0; nreq = 0;

    @(negedge sys_clk);
    command = cmd; data0 = d0; core_halted = halted; cmd_update = 1'b1;
    @(negedge sys_clk);
    cmd_update = 1'b0;
    i = 1;
    while (fin_obs == 0 && i <= fin_exp + 8) begin
      dbg_reg_ack   = 1'b0;
      dbg_reg_rdata = $urandom;
      if (!cmd_busy) busy_bad = 1;
      if (dbg_reg_req) begin
        if (nreq == 0) begin
          a_obs = dbg_reg_addr; we_obs = dbg_reg_we; wd_obs = dbg_reg_wdata;
        end
        if (nreq == dly) begin
          dbg_reg_ack = 1'b1; dbg_reg_rdata = rd;
        end
        nreq++;
      end
      if (cmd_finished) begin
        fin_obs = i;
        rd_obs  = cmd_read_data;
      end else begin
        if (cmd_read_data != 32'h0) leak = 1;
        @(negedge sys_clk);
        i++;
      end
    end
    dbg_reg_ack = 1'b0;
    @(negedge sys_clk);
    chk("idle_busy",  32'(cmd_busy), 32'h0);
    chk("idle_fin",   32'(cmd_finished), 32'h0);
    chk("fin_cycle",  32'(fin_obs), 32'(fin_exp));
    chk("req_cycles", 32'(nreq), 32'(nreq_exp));
    if (nreq_exp > 0) begin
      chk("req_addr",  32'(a_obs), 32'(cmd[15:0]));
      chk("req_we",    32'(we_obs), 32'(cmd[16]));
      chk("req_wdata", wd_obs, d0);
    end
    chk("read_data", rd_obs, rd_exp);
    chk("rd_leak",   32'(leak), 32'h0);
    chk("busy_held", 32'(busy_bad), 32'h0);
    if (err_m == 0) err_m = code;
    chk("cmderr", 32'(cmd_err), 32'(err_m));
  endtask

  initial begin
    int i, fin, nreq, dsel, dly;
    logic halted;

    sys_rstn = 1'b0; command = '0; cmd_update = 1'b0; data0 = '0; cmderr_clr = 1'b0;
    core_halted = 1'b0; dbg_reg_ack = 1'b0; dbg_reg_rdata = '0;

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_req",   32'(dbg_reg_req), 32'h0);
    chk("rst_busy",  32'(cmd_busy), 32'h0);
    chk("rst_fin",   32'(cmd_finished), 32'h0);
    chk("rst_err",   32'(cmd_err), 32'h0);
    chk("rst_rdata", cmd_read_data, 32'h0);
    chk("rst_addr",  32'(dbg_reg_addr), 32'h0);
    sys_rstn = 1'b1;

    // GPR read, CSR write, boundary regnos, x0 write
    run_cmd(32'h0022_1005, 32'h0,         1'b1, 2, 32'hDEAD_BEEF);
    run_cmd(32'h0023_07B1, 32'h1234_5678, 1'b1, 0, 32'hAAAA_5555);
    run_cmd(32'h0022_101F, 32'h0,         1'b1, 1, 32'h0BAD_F00D);
    run_cmd(32'h0022_0FFF, 32'h0,         1'b1, TIMEOUT - 1, 32'h7777_0001);
    run_cmd(32'h0023_1000, 32'hFFFF_0000, 1'b1, 0, 32'h0);

    // Not halted, then a later error must not overwrite, then clear
    run_cmd(32'h0022_1001, 32'h0, 1'b0, 0, 32'h0);
    run_cmd(32'h0122_1001, 32'h0, 1'b1, 0, 32'h0);
    clr_err();

    // Unsupported commands
    run_cmd(32'h0032_1005, 32'h0, 1'b1, 0, 32'h0);
    clr_err();
    run_cmd(32'h0122_1005, 32'h0, 1'b1, 0, 32'h0);
    clr_err();
    run_cmd(32'h0022_1020, 32'h0, 1'b1, 0, 32'h0);
    clr_err();
    run_cmd(32'h0026_1005, 32'h0, 1'b1, 0, 32'h0);
    clr_err();
    run_cmd(32'h0020_1020, 32'h0, 1'b1, 0, 32'h0);

    // Busy error mid-REQ while the core never acks; command runs to timeout
    @(negedge sys_clk);
    command = 32'h0022_1005; core_halted = 1'b1; cmd_update = 1'b1;
    @(negedge sys_clk);
    cmd_update = 1'b0;
    i = 1; fin = 0; nreq = 0;
    while (fin == 0 && i < TIMEOUT + 20) begin
      if (i == 4) begin
        command = 32'h0023_0300; cmd_update = 1'b1;
      end else begin
        cmd_update = 1'b0;
      end
      if (i == 5) begin
        chk("busy_err",  32'(cmd_err), 32'h1);
        chk("busy_addr", 32'(dbg_reg_addr), 32'h1005);
        chk("busy_we",   32'(dbg_reg_we), 32'h0);
      end
      if (dbg_reg_req) nreq++;
      if (cmd_finished) begin
        fin = i;
        chk("busy_rd", cmd_read_data, 32'h0);
      end else begin
        @(negedge sys_clk);
        i++;
      end
    end
    cmd_update = 1'b0;
    err_m = 1;
    chk("to_fin_cycle", 32'(fin), 32'(2 + TIMEOUT));
    chk("to_req_cycles", 32'(nreq), 32'(TIMEOUT));
    @(negedge sys_clk);
    chk("to_err", 32'(cmd_err), 32'(err_m));
    chk("to_idle", 32'(cmd_busy), 32'h0);
    clr_err();

    // Reset during REQ
    @(negedge sys_clk);
    command = 32'h0022_1003; core_halted = 1'b1; cmd_update = 1'b1;
    @(negedge sys_clk);
    cmd_update = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_pre_req", 32'(dbg_reg_req), 32'h1);
    #2 sys_rstn = 1'b0;
    #1;
    chk("rst_mid_req",  32'(dbg_reg_req), 32'h0);
    chk("rst_mid_busy", 32'(cmd_busy), 32'h0);
    @(negedge sys_clk);
    chk("rst_mid_fin", 32'(cmd_finished), 32'h0);
    sys_rstn = 1'b1;
    err_m = 0;
    run_cmd(32'h0022_100A, 32'h0, 1'b1, 1, 32'hC0DE_1234);

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      halted = ($urandom_range(0, 9) != 0);
      dsel   = $urandom_range(0, 7);
      if (dsel < 6)       dly = dsel;
      else if (dsel == 6) dly = TIMEOUT - 1;
      else                dly = TIMEOUT + 2;
      run_cmd(rand_cmd(), $urandom, halted, dly, $urandom);
      if (err_m != 0 && $urandom_range(0, 1) == 1) clr_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
